// File: rtl/call_stack.sv
// Return-address stack for jms/bbl handling.
// It holds up to DEPTH entries. The top entry is presented combinationally so
// the decoder can load the PC and pop on the same edge. Overflow and underflow
// are sticky error flags that stay set until clear_err.
module call_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic                     clear_err,
  output logic [ADDR_W-1:0]        top_addr,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] entry_q, entry_d;
  logic [SP_W-1:0]              sp_q, sp_d;
  logic                         ovf_q, ovf_d;
  logic                         unf_q, unf_d;

  logic             is_empty, is_full;
  logic [IDX_W-1:0] wr_idx, top_idx;

  // Decode the pointer. Each index is only used when the stack state makes it valid.
  always_comb begin
    is_empty = (sp_q == '0);
    is_full  = (sp_q == SP_MAX);
    wr_idx   = sp_q[IDX_W-1:0];
    top_idx  = IDX_W'(sp_q - SP_ONE);
  end

  assign top_addr  = is_empty ? '0 : entry_q[top_idx];
  assign depth     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Next-state logic. clear_err is applied first, so an error event in the
  // same cycle sets its flag again.
  always_comb begin
    entry_d = entry_q;
    sp_d    = sp_q;
    ovf_d   = clear_err ? 1'b0 : ovf_q;
    unf_d   = clear_err ? 1'b0 : unf_q;
    unique case ({push, pop})
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          entry_d[wr_idx] = push_addr;
          sp_d            = sp_q + SP_ONE;
        end
      end
      2'b01: begin
        if (is_empty) unf_d = 1'b1;
        else          sp_d  = sp_q - SP_ONE;
      end
      2'b11: begin
        // On an empty stack this acts as a plain push. DEPTH >= 2, so the
        // stack cannot be full at the same time.
        if (is_empty) begin
          entry_d[wr_idx] = push_addr;
          sp_d            = sp_q + SP_ONE;
        end else begin
          entry_d[top_idx] = push_addr;
        end
      end
      default: ;
    endcase
  end

  // State registers. Entries are cleared on reset so top_addr never shows X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack. It runs directed scenarios, then random traffic.
// Every step is checked against a queue-based stack model.
module tb_call_stack;
  localparam int AW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic [AW-1:0] top_addr;
  logic [$clog2(D):0] depth;
  logic          empty, full, overflow, underflow;

  call_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
    .clear_err(clear_err), .top_addr(top_addr), .depth(depth), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue whose back is the top of the stack.
  int q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  function automatic int m_top();
    return (q.size() > 0) ? q[q.size()-1] : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("depth",     32'(depth),     32'(q.size()));
    chk("top_addr",  32'(top_addr),  32'(m_top()));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("full",      32'(full),      32'(q.size() == D));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Drive one cycle, check the combinational top before the edge, then
  // update the model and check all outputs after the edge.
  task automatic step(input bit pu, input bit po, input logic [AW-1:0] a, input bit clr);
    @(negedge clk);
    push = pu; pop = po; push_addr = a; clear_err = clr;
    #1 chk("pre_edge_top", 32'(top_addr), 32'(m_top()));
    @(posedge clk);
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (pu && !po) begin
      if (q.size() == D) m_ovf = 1'b1;
      else               q.push_back(int'(a));
    end else if (po && !pu) begin
      if (q.size() == 0) m_unf = 1'b1;
      else               void'(q.pop_back());
    end else if (pu && po) begin
      if (q.size() == 0) q.push_back(int'(a));
      else               q[q.size()-1] = int'(a);
    end
    #1 check_all();
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  task automatic reset_consts(input string tag);
    chk({tag, "_depth"}, 32'(depth), 0);
    chk({tag, "_top"},   32'(top_addr), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_unf"},   32'(underflow), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 reset_consts("rst");
    @(negedge clk); rst_n = 1'b1;

    // Two pushes, then two pops down to empty
    step(1, 0, 8'h12, 0);
    step(1, 0, 8'h34, 0);
    chk("r32_depth", 32'(depth), 2);
    chk("r32_top",   32'(top_addr), 32'h34);
    chk("r32_empty", 32'(empty), 0);
    chk("r32_full",  32'(full), 0);
    step(0, 1, 0, 0);
    chk("r33_top1", 32'(top_addr), 32'h12);
    step(0, 1, 0, 0);
    chk("r33_empty", 32'(empty), 1);
    chk("r33_top0",  32'(top_addr), 0);
    chk("r33_unf",   32'(underflow), 0);

    // Fill the stack, overflow it, then clear the error
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, AW'(i), 0);
      if (i == 4) chk("r34_full", 32'(full), 1);
    end
    chk("r34_ovf", 32'(overflow), 1);
    chk("r34_top", 32'(top_addr), 32'h04);
    step(0, 0, 0, 1);
    chk("r34_clr", 32'(overflow), 0);

    // Underflow, then a push leaves the flag sticky
    repeat (4) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("r35_unf",   32'(underflow), 1);
    chk("r35_depth", 32'(depth), 0);
    step(1, 0, 8'h20, 0);
    chk("r35_top",  32'(top_addr), 32'h20);
    chk("r35_unf2", 32'(underflow), 1);
    step(0, 1, 0, 1);

    // Replace top, push+pop on empty, and an error in the same cycle as clear
    step(1, 0, 8'h10, 0);
    step(1, 0, 8'h11, 0);
    step(1, 1, 8'h99, 0);
    chk("r36_depth", 32'(depth), 2);
    chk("r36_top",   32'(top_addr), 32'h99);
    step(0, 1, 0, 0);
    chk("r36_pop", 32'(top_addr), 32'h10);
    step(0, 1, 0, 0);
    step(1, 1, 8'h77, 0);
    chk("pp_empty_unf", 32'(underflow), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("clr_vs_err", 32'(underflow), 1);
    step(0, 0, 0, 1);

    // Asynchronous reset in the middle of a cycle
    step(1, 0, 8'hA1, 0);
    step(1, 0, 8'hA2, 0);
    step(1, 0, 8'hA3, 0);
    #2 rst_n = 1'b0;
    #1 reset_consts("async");
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(1, 0, 8'h55, 0);
    chk("r37_depth", 32'(depth), 1);
    chk("r37_top",   32'(top_addr), 32'h55);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      step(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, AW'($urandom),
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
